// File: rtl/raster_pkg.sv
// Shared definitions for the AHB triangle rasteriser: FSM states,
// register word addresses and STATUS bit positions.
// Pure declarations, no logic.
package raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Word addresses (HADDR[5:2])
  localparam logic [3:0] A_X1     = 4'd0;
  localparam logic [3:0] A_Y1     = 4'd1;
  localparam logic [3:0] A_X2     = 4'd2;
  localparam logic [3:0] A_Y2     = 4'd3;
  localparam logic [3:0] A_X3     = 4'd4;
  localparam logic [3:0] A_Y3     = 4'd5;
  localparam logic [3:0] A_CTRL   = 4'd6;
  localparam logic [3:0] A_STATUS = 4'd7;
  localparam logic [3:0] A_MASK   = 4'd8;
  localparam logic [3:0] A_POS    = 4'd9;

  // STATUS bit positions
  localparam int unsigned SB_BUSY   = 0;
  localparam int unsigned SB_DONE   = 1;
  localparam int unsigned SB_EMPTY  = 2;
  localparam int unsigned SB_FULL   = 3;
  localparam int unsigned SB_DEGEN  = 4;
  localparam int unsigned SB_CNT_LO = 16;

endpackage

// File: rtl/raster_fifo.sv
// Purpose: synchronous single-clock FIFO holding rasteriser result chunks.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: push_rdy low when full unless a pop happens the same cycle; flush wins over push/pop.
module raster_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     push_rdy,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_dat  = mem_q[rd_ptr_q];
  assign push_rdy = !full || (pop_vld && !empty);
  assign do_push  = push_vld && push_rdy && !flush;
  assign do_pop   = pop_vld && !empty && !flush;

  // pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
      if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    end
  end

  // storage write; contents are don't-care until pushed
  always_ff @(posedge HCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  // state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ahb_raster_vec.sv
// Purpose: AHB-Lite slave that rasterises one triangle, LANES pixels per cycle, into a result FIFO.
// Latency: SETUP takes 1 cycle after start, then one chunk per cycle; reads are zero-wait-state.
// Backpressure: scan stalls in place while the result FIFO is full; MASK reads pop it.
module ahb_raster_vec
  import raster_pkg::*;
#(
  parameter int COORD_W    = 16,
  parameter int LANES      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SKIP_EMPTY = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT
);

  localparam int EW   = 2*COORD_W + 3;    // edge function width, overflow-free
  localparam int XW   = COORD_W + 6;      // x0 may step past xmax by up to LANES
  localparam int DW   = 2*COORD_W + LANES;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [EW-1:0]      edge_t;
  typedef logic signed [XW-1:0]      xw_t;

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic        dph_vld_q, dph_vld_d, dph_wr_q, dph_wr_d;
  logic [3:0]  dph_addr_q, dph_addr_d;
  state_e      state_q, state_d;
  coord_t      vert_q [6];
  coord_t      vert_d [6];
  edge_t       d_q, d_d;
  coord_t      xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d, y_q, y_d;
  xw_t         x0_q, x0_d, x0_next;
  logic        degen_q, degen_d;

  logic        wr_en, rd_en, ctrl_wr, abort, start, busy, flush;
  edge_t       ex1, ey1, ex2, ey2, ex3, ey3, a1, b1, a2, b2, d_comb;
  logic [LANES-1:0] mask;
  logic        push_want, push_rdy, stall, row_end, pop_vld;
  logic [DW-1:0]    pop_dat;
  logic        fifo_empty, fifo_full;
  logic [CNTW-1:0]  fifo_cnt;
  coord_t      head_x, head_y;
  logic [15:0] head_x16, head_y16;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:6], HADDR[1:0], HWDATA[31:COORD_W]};
  assign HREADYOUT   = 1'b1;

  assign wr_en   = dph_vld_q && dph_wr_q;
  assign rd_en   = dph_vld_q && !dph_wr_q;
  assign busy    = (state_q == ST_SETUP) || (state_q == ST_SCAN);
  assign ctrl_wr = wr_en && (dph_addr_q == A_CTRL);
  assign abort   = ctrl_wr && HWDATA[1];
  assign start   = ctrl_wr && HWDATA[0] && !HWDATA[1] && !busy;
  assign flush   = abort || start;
  assign pop_vld = rd_en && (dph_addr_q == A_MASK);

  assign ex1 = edge_t'(vert_q[0]);
  assign ey1 = edge_t'(vert_q[1]);
  assign ex2 = edge_t'(vert_q[2]);
  assign ey2 = edge_t'(vert_q[3]);
  assign ex3 = edge_t'(vert_q[4]);
  assign ey3 = edge_t'(vert_q[5]);
  assign a1  = ey2 - ey3;
  assign b1  = ex3 - ex2;
  assign a2  = ey3 - ey1;
  assign b2  = ex1 - ex3;
  assign d_comb = a1 * (ex1 - ex3) + b1 * (ey1 - ey3);

  // capture AHB address phase for use in the following data phase
  always_comb begin
    dph_vld_d  = dph_vld_q;
    dph_wr_d   = dph_wr_q;
    dph_addr_d = dph_addr_q;
    if (HREADY) begin
      dph_vld_d  = HSEL && (HTRANS != 2'b00);
      dph_wr_d   = HWRITE;
      dph_addr_d = HADDR[5:2];
    end
  end

  // per-lane inside test for the current chunk at (x0_q + i, y_q)
  always_comb begin
    xw_t   px;
    edge_t dx, dy, e1, e2, es;
    logic  ins;
    mask = '0;
    dy   = edge_t'(y_q) - ey3;
    for (int i = 0; i < LANES; i++) begin
      px = x0_q + xw_t'(i);
      dx = edge_t'(px) - ex3;
      e1 = a1 * dx + b1 * dy;
      e2 = a2 * dx + b2 * dy;
      es = e1 + e2;
      if (!d_q[EW-1])
        ins = !e1[EW-1] && !e2[EW-1] && (es <= d_q);
      else
        ins = (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0) && (es >= d_q);
      mask[i] = ins && (px <= xw_t'(xmax_q));
    end
  end

  assign push_want = (state_q == ST_SCAN) && ((mask != '0) || (SKIP_EMPTY == 0));
  assign stall     = push_want && !push_rdy;
  assign x0_next   = x0_q + xw_t'(LANES);
  assign row_end   = x0_next > xw_t'(xmax_q);

  // FSM next state, vertex writes and scan position
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x0_d    = x0_q;
    y_d     = y_q;
    degen_d = degen_q;
    for (int i = 0; i < 6; i++) begin
      vert_d[i] = vert_q[i];
      if (wr_en && !busy && (dph_addr_q == 4'(i))) vert_d[i] = HWDATA[COORD_W-1:0];
    end
    case (state_q)
      ST_SETUP: begin
        d_d     = d_comb;
        xmin_d  = min3(vert_q[0], vert_q[2], vert_q[4]);
        xmax_d  = max3(vert_q[0], vert_q[2], vert_q[4]);
        ymin_d  = min3(vert_q[1], vert_q[3], vert_q[5]);
        ymax_d  = max3(vert_q[1], vert_q[3], vert_q[5]);
        x0_d    = xw_t'(min3(vert_q[0], vert_q[2], vert_q[4]));
        y_d     = min3(vert_q[1], vert_q[3], vert_q[5]);
        degen_d = (d_comb == '0);
        state_d = (d_comb == '0) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        if (!stall) begin
          if (!row_end) begin
            x0_d = x0_next;
          end else if (y_q == ymax_q) begin
            state_d = ST_DONE;
          end else begin
            y_d  = y_q + coord_t'(1);
            x0_d = xw_t'(xmin_q);
          end
        end
      end
      default: ;
    endcase
    if (start) begin
      state_d = ST_SETUP;
      degen_d = 1'b0;
    end
    if (abort) begin
      state_d = ST_IDLE;
      degen_d = 1'b0;
    end
  end

  raster_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .flush    (flush),
    .push_vld (push_want),
    .push_dat ({x0_q[COORD_W-1:0], y_q, mask}),
    .push_rdy (push_rdy),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_cnt)
  );

  assign head_x   = pop_dat[DW-1 -: COORD_W];
  assign head_y   = pop_dat[LANES +: COORD_W];
  assign head_x16 = 16'(head_x);
  assign head_y16 = 16'(head_y);

  // read data mux for the data phase
  always_comb begin
    status = '0;
    status[SB_BUSY]  = busy;
    status[SB_DONE]  = (state_q == ST_DONE);
    status[SB_EMPTY] = fifo_empty;
    status[SB_FULL]  = fifo_full;
    status[SB_DEGEN] = degen_q;
    status[SB_CNT_LO +: 8] = 8'(fifo_cnt);
    HRDATA = '0;
    if (rd_en) begin
      case (dph_addr_q)
        A_STATUS: HRDATA = status;
        A_MASK:   if (!fifo_empty) HRDATA = 32'(pop_dat[LANES-1:0]);
        A_POS:    if (!fifo_empty) HRDATA = {head_y16, head_x16};
        default:  ;
      endcase
    end
  end

  // state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_vld_q  <= 1'b0;
      dph_wr_q   <= 1'b0;
      dph_addr_q <= '0;
      state_q    <= ST_IDLE;
      d_q        <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      x0_q       <= '0;
      y_q        <= '0;
      degen_q    <= 1'b0;
      for (int i = 0; i < 6; i++) vert_q[i] <= '0;
    end else begin
      dph_vld_q  <= dph_vld_d;
      dph_wr_q   <= dph_wr_d;
      dph_addr_q <= dph_addr_d;
      state_q    <= state_d;
      d_q        <= d_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
      x0_q       <= x0_d;
      y_q        <= y_d;
      degen_q    <= degen_d;
      for (int i = 0; i < 6; i++) vert_q[i] <= vert_d[i];
    end
  end

endmodule

// File: tb/tb_ahb_raster_vec.sv
// Scoreboard bench for ahb_raster_vec: reads push hand-computed expected
// words into a queue, a monitor compares every read data phase against it.
// Directed triangles cover fill/stall, D<0, partial chunks, degenerate, abort, reset.
module tb_ahb_raster_vec;

  localparam logic [3:0] X1 = 4'd0, Y1 = 4'd1, X2 = 4'd2, Y2 = 4'd3, X3 = 4'd4, Y3 = 4'd5;
  localparam logic [3:0] CTRL = 4'd6, STATUS = 4'd7, MASK = 4'd8, POS = 4'd9;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HSEL, HREADYOUT;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        rd_dph = 1'b0;
  logic        stim_done = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_raster_vec #(.COORD_W(16), .LANES(8), .FIFO_DEPTH(4), .SKIP_EMPTY(1)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSEL      (HSEL),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT)
  );

  // bench-side view of which cycles are read data phases
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rd_dph <= 1'b0;
    else          rd_dph <= HSEL && (HTRANS != 2'b00) && HREADY && !HWRITE;
  end

  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h", n, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge HCLK);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {26'd0, a, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {26'd0, a, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic set_tri(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3);
    wr(X1, x1); wr(Y1, y1); wr(X2, x2); wr(Y2, y2); wr(X3, x3); wr(Y3, y3);
  endtask

  // right triangle legs 7: eight rows, row k at x0=0 with mask 0xFF>>k
  task automatic drain_rows(input string tag);
    for (int k = 0; k < 8; k++) begin
      rd(POS, 32'(k) << 16, $sformatf("%s_pos%0d", tag, k));
      rd(MASK, 32'hFF >> k, $sformatf("%s_mask%0d", tag, k));
      if (k == 3) rd(STATUS, 32'h0004_000A, {tag, "_done_after4"});
    end
    rd(STATUS, 32'h0000_0006, {tag, "_done_empty"});
  endtask

  // monitor: every read data phase pops one expectation
  initial begin : monitor
    logic [31:0] e;
    string       n;
    @(negedge HCLK);
    cmp("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    cmp("rst_hrdata", HRDATA, 32'd0);
    for (int c = 0; c < 20000 && !stim_done; c++) begin
      @(negedge HCLK);
      if (rd_dph) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_read", HRDATA, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          cmp(n, HRDATA, e);
        end
      end
    end
    if (!stim_done) cmp("timeout", 32'd0, 32'd1);
    cmp("leftover_expect", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stimulus
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
    HSIZE = 3'b010; HREADY = 1'b1;
    cyc(3); #1;
    HRESETn = 1'b1;
    rd(STATUS, 32'h0000_0004, "rst_status");
    rd(POS, 32'd0, "rst_pos_empty");
    rd(MASK, 32'd0, "rst_mask_empty");

    // D>0 right triangle; FIFO fills, scan stalls busy
    set_tri(0, 0, 7, 0, 0, 7);
    wr(CTRL, 32'd1);
    cyc(30);
    rd(STATUS, 32'h0004_0009, "t1_full");
    wr(X2, 32'd1);
    wr(CTRL, 32'd1);
    rd(STATUS, 32'h0004_0009, "t1_busy_start_ignored");
    drain_rows("t1");
    rd(MASK, 32'd0, "t1_mask_when_empty");
    rd(STATUS, 32'h0000_0006, "t1_no_underflow");

    // same triangle with reversed winding (D<0)
    set_tri(0, 0, 0, 7, 7, 0);
    wr(CTRL, 32'd1);
    cyc(30);
    rd(STATUS, 32'h0004_0009, "t2_full");
    drain_rows("t2");

    // partial second chunk, empty chunk skipped
    set_tri(0, 0, 9, 0, 0, 1);
    wr(CTRL, 32'd1);
    cyc(20);
    rd(STATUS, 32'h0003_0002, "t3_status");
    rd(POS,  32'h0000_0000, "t3_pos0");
    rd(MASK, 32'h0000_00FF, "t3_mask0");
    rd(POS,  32'h0000_0008, "t3_pos1");
    rd(MASK, 32'h0000_0003, "t3_mask1");
    rd(POS,  32'h0001_0000, "t3_pos2");
    rd(MASK, 32'h0000_0001, "t3_mask2");
    rd(STATUS, 32'h0000_0006, "t3_done_empty");

    // collinear vertices: degenerate, done in two cycles
    set_tri(0, 0, 2, 2, 4, 4);
    wr(CTRL, 32'd1);
    rd(STATUS, 32'h0000_0016, "t4_degenerate");
    rd(MASK, 32'd0, "t4_no_entries");
    wr(CTRL, 32'd3);
    rd(STATUS, 32'h0000_0004, "t4_abort_beats_start");

    // negative coordinates, then abort while FIFO full
    set_tri(-3, -3, 4, -3, -3, 4);
    wr(CTRL, 32'd1);
    cyc(30);
    rd(POS,  32'hFFFD_FFFD, "t5_pos0");
    rd(MASK, 32'h0000_00FF, "t5_mask0");
    rd(POS,  32'hFFFE_FFFD, "t5_pos1");
    rd(MASK, 32'h0000_007F, "t5_mask1");
    cyc(10);
    rd(STATUS, 32'h0004_0009, "t5_full_again");
    wr(CTRL, 32'd2);
    rd(STATUS, 32'h0000_0004, "t5_abort_full");

    // reset pulse mid-scan discards everything, vertices return to 0
    set_tri(0, 0, 7, 0, 0, 7);
    wr(CTRL, 32'd1);
    cyc(3); #1;
    HRESETn = 1'b0;
    cyc(2); #1;
    HRESETn = 1'b1;
    rd(STATUS, 32'h0000_0004, "t6_after_reset");
    cyc(20);
    rd(STATUS, 32'h0000_0004, "t6_no_entries");
    rd(MASK, 32'd0, "t6_mask_empty");
    wr(CTRL, 32'd1);
    rd(STATUS, 32'h0000_0016, "t6_vertices_zero");

    cyc(4);
    stim_done = 1'b1;
  end

endmodule

// File: doc/ahb_raster_vec.md
AHB_RASTER_VEC -- requirements
Module: ahb_raster_vec

Interface
REQ-001 SHALL have parameter COORD_W, default 16, signed vertex/pixel coordinate width (2..16).
REQ-002 SHALL have parameter LANES, default 8, pixels evaluated per cycle along x (1..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, result FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter SKIP_EMPTY, default 1; 1 means all-zero masks are not pushed.
REQ-005 HCLK  input  1  AHB clock; all state on rising edge.
REQ-006 HRESETn  input  1  reset, asynchronous, active-low.
REQ-007 HADDR  input  32; HWDATA input 32; HSIZE input 3; HTRANS input 2; HWRITE, HREADY, HSEL input 1 -- AHB-Lite slave inputs, word transfers only, HADDR[5:2] decoded.
REQ-008 HRDATA  output  32  read data; HREADYOUT  output  1  tied 1 (zero wait states).

Function
REQ-009 Address phase captured when HREADY&HSEL&HTRANS!=0; write/read acts in the following data phase.
REQ-010 Map (word): 0..5 X1,Y1,X2,Y2,X3,Y3 (W, low COORD_W bits, sign-extended); 6 CTRL (W: bit0 start, bit1 abort); 7 STATUS (R); 8 MASK (R, pops); 9 POS (R, no pop); others read 0, writes ignored.
REQ-011 STATUS: bit0 busy, bit1 done, bit2 fifo_empty, bit3 fifo_full, bit4 degenerate, [23:16] fifo count.
REQ-012 POS returns {head y[15:0], head x[15:0]} (two's complement, sign-extended to 16); MASK returns head mask zero-extended; both return 0 when FIFO empty; MASK read when empty does not pop.
REQ-013 FSM states IDLE, SETUP, SCAN, DONE; start in any state except SETUP/SCAN -> SETUP next cycle, FIFO flushed, done/degenerate cleared.
REQ-014 SETUP (1 cycle): compute D=(y2-y3)(x1-x3)+(x3-x2)(y1-y3), bbox = min/max of vertex x and y; D==0 -> DONE with degenerate=1, no entries; else SCAN at (xmin,ymin).
REQ-015 Lane i pixel (x0+i,y): E1=(y2-y3)(x-x3)+(x3-x2)(y-y3), E2=(y3-y1)(x-x3)+(x1-x3)(y-y3); inside iff D>0: E1>=0,E2>=0,E1+E2<=D; or D<0: E1<=0,E2<=0,E1+E2>=D (edges inclusive).
REQ-016 Edge arithmetic SHALL be signed, 2*COORD_W+3 bits, with no overflow for any legal input.
REQ-017 SCAN: one chunk per cycle; push {x0,y,mask} unless FIFO full (stall, no advance) or mask==0 with SKIP_EMPTY=1; lanes with x0+i>xmax masked 0.
REQ-018 Chunk order: x0 = xmin, xmin+LANES, ... while x0<=xmax; then y+1, x0=xmin; after chunk at (last x0, ymax) -> DONE.
REQ-019 Simultaneous push and pop when full SHALL both occur, count unchanged.
REQ-020 Vertex writes while busy SHALL be ignored; start while busy SHALL be ignored.
REQ-021 Abort in any state -> IDLE next cycle, FIFO flushed, done=0, degenerate=0; abort with start in the same word: abort wins.
REQ-022 busy = state in {SETUP,SCAN}; done = state DONE; done remains set until start/abort.

Reset
REQ-023 On HRESETn low: state IDLE, vertices 0, FIFO empty, all flags 0, captured address-phase controls 0; HRDATA 0, HREADYOUT 1.
REQ-024 Reset mid-scan SHALL discard all progress; no entry pushed in the first cycle after release.

Structure
REQ-025 Package raster_pkg SHALL hold the FSM state enum, word-address localparams and STATUS bit positions.
REQ-026 Result FIFO SHALL be sub-module raster_fifo (sync, single clock, parametrised width/depth, count output).

Verification (COORD_W=16, LANES=8, FIFO_DEPTH=4)
REQ-027 (0,0),(7,0),(0,7), start -> 8 entries, row y mask 0xFF>>y at x0=0; FIFO fills after 4, busy holds until 4 MASK reads, then done.
REQ-028 (0,0),(0,7),(7,0) (D<0) -> identical entry sequence to REQ-027.
REQ-029 (0,0),(9,0),(0,1) -> entries (0,0,0xFF),(8,0,0x03),(0,1,0x01); (8,1) skipped.
REQ-030 (0,0),(2,2),(4,4) -> done=1, degenerate=1 within 2 cycles of start, fifo_empty=1.
REQ-031 (-3,-3),(4,-3),(-3,4) -> first POS=0xFFFDFFFD, MASK=0xFF.
REQ-032 Abort with FIFO full mid-scan -> next cycle STATUS=0x04; HRESETn pulse mid-scan -> STATUS=0x04, no further entries.
